mem_arbiter_rr: RTL and testbench



---
 rtl/arb_pkg.sv | 11 +
 rtl/rr_picker.sv | 35 +++
 rtl/mem_arbiter_rr.sv | 127 ++++++++++++
 tb/tb_mem_arbiter_rr.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the N-channel round-robin memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_e;

  // $clog2 with a floor of one bit so single-value ranges still get a vector.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: round-robin upward from ptr, or lowest index.
module rr_picker
  import arb_pkg::*;
#(
  parameter  int NCH = 2,
  localparam int GW  = clog2_min1(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [GW-1:0]  ptr,
  input  logic           rr_en,
  output logic           found,
  output logic [GW-1:0]  idx
);

  always_comb begin
    int unsigned base;
    int unsigned c;
    found = 1'b0;
    idx   = '0;
    base  = 0;
    c     = 0;
    if (rr_en) base = 32'(ptr);
    if (base >= NCH) base = 0;
    // Candidate order wraps explicitly so non-power-of-2 NCH never aliases.
    for (int unsigned i = 0; i < NCH; i++) begin
      c = base + i;
      if (c >= NCH) c = c - NCH;
      if (!found && req[GW'(c)]) begin
        found = 1'b1;
        idx   = GW'(c);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel memory arbiter: one outstanding transaction, response watchdog, registered outputs.
module mem_arbiter_rr
  import arb_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int ADDR_W  = 64,
  parameter int BLOCKSZ = 512,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        req_valid,
  input  logic [NCH*ADDR_W-1:0] req_addr,
  input  logic [NCH-1:0]        req_wr_en,
  input  logic [NCH*BLOCKSZ-1:0] req_wdata,
  output logic [NCH-1:0]        resp_done,
  output logic                  resp_err,
  output logic [BLOCKSZ-1:0]    resp_rdata,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_wr_en,
  output logic [BLOCKSZ-1:0]    mem_data_out,
  input  logic [BLOCKSZ-1:0]    mem_data_in,
  input  logic                  mem_data_valid
);

  localparam int GRANT_W = clog2_min1(NCH);
  localparam int WD_W    = clog2_min1(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_state_e         state;
  logic [GRANT_W-1:0] rr_ptr;
  logic [GRANT_W-1:0] grant;
  logic [WD_W-1:0]    wd;

  logic               pick_found;
  logic [GRANT_W-1:0] pick_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic               sel_wr;
  logic [BLOCKSZ-1:0] sel_wdata;
  logic [NCH-1:0]     grant_oh;

  rr_picker #(.NCH(NCH)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .rr_en (RR_EN != 0),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wr    = 1'b0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (pick_idx == GRANT_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wr    = req_wr_en[i];
        sel_wdata = req_wdata[i*BLOCKSZ +: BLOCKSZ];
      end
    end
  end

  always_comb begin
    grant_oh        = '0;
    grant_oh[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      wd           <= '0;
      resp_done    <= '0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      mem_req      <= 1'b0;
      mem_address  <= '0;
      mem_wr_en    <= 1'b0;
      mem_data_out <= '0;
    end else begin
      mem_req   <= 1'b0;
      resp_done <= '0;
      resp_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant        <= pick_idx;
            mem_address  <= sel_addr;
            mem_wr_en    <= sel_wr;
            mem_data_out <= sel_wdata;
            mem_req      <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Completion pulses are registered here so they appear during DONE.
          if (mem_data_valid) begin
            resp_rdata <= mem_data_in;
            resp_done  <= grant_oh;
            state      <= DONE;
          end else if (TIMEOUT != 0 && wd == WD_LAST) begin
            resp_done <= grant_oh;
            resp_err  <= 1'b1;
            state     <= DONE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        DONE: begin
          if (grant == GRANT_W'(NCH - 1)) rr_ptr <= '0;
          else                            rr_ptr <= grant + 1'b1;
          wd    <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench: round-robin and fixed-priority arbiters against a transaction-level model.
module tb_mem_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int BW = 512;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            sel = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_wr_en;
  logic [N*BW-1:0] req_wdata;
  logic [BW-1:0]   mem_data_in = '0;
  logic            mem_data_valid = 1'b0;

  logic [N-1:0]  a_done, b_done, o_done;
  logic          a_err, b_err, o_err;
  logic [BW-1:0] a_rdata, b_rdata, o_rdata;
  logic          a_mreq, b_mreq, o_mreq;
  logic [AW-1:0] a_maddr, b_maddr, o_maddr;
  logic          a_mwr, b_mwr, o_mwr;
  logic [BW-1:0] a_mdo, b_mdo, o_mdo;

  // Requester-side view: pending mask plus per-channel request contents.
  logic [N-1:0]  pend = '0;
  logic [AW-1:0] r_addr [N];
  logic          r_wr   [N];
  logic [BW-1:0] r_data [N];
  int            exp_ptr = 0;
  logic [BW-1:0] exp_rdata = '0;
  logic [BW-1:0] next_rd;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_valid = pend;
    req_addr  = '0;
    req_wr_en = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = r_addr[i];
      req_wr_en[i]          = r_wr[i];
      req_wdata[i*BW +: BW] = r_data[i];
    end
  end

  assign o_done  = sel ? b_done  : a_done;
  assign o_err   = sel ? b_err   : a_err;
  assign o_rdata = sel ? b_rdata : a_rdata;
  assign o_mreq  = sel ? b_mreq  : a_mreq;
  assign o_maddr = sel ? b_maddr : a_maddr;
  assign o_mwr   = sel ? b_mwr   : a_mwr;
  assign o_mdo   = sel ? b_mdo   : a_mdo;

  mem_arbiter_rr #(.NCH(N), .ADDR_W(AW), .BLOCKSZ(BW), .RR_EN(1), .TIMEOUT(16)) dut_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_wr_en(req_wr_en), .req_wdata(req_wdata), .resp_done(a_done), .resp_err(a_err),
    .resp_rdata(a_rdata), .mem_req(a_mreq), .mem_address(a_maddr), .mem_wr_en(a_mwr),
    .mem_data_out(a_mdo), .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid)
  );

  mem_arbiter_rr #(.NCH(N), .ADDR_W(AW), .BLOCKSZ(BW), .RR_EN(0), .TIMEOUT(16)) dut_fp (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_wr_en(req_wr_en), .req_wdata(req_wdata), .resp_done(b_done), .resp_err(b_err),
    .resp_rdata(b_rdata), .mem_req(b_mreq), .mem_address(b_maddr), .mem_wr_en(b_mwr),
    .mem_data_out(b_mdo), .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid)
  );

  function automatic logic [BW-1:0] rand512();
    logic [BW-1:0] v;
    for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Spec rule: first pending channel at or after ptr (cyclic), or lowest index.
  function automatic int model_pick(input logic [N-1:0] m, input int ptr, input bit rr);
    for (int k = 0; k < N; k++) begin
      int c;
      c = rr ? (ptr + k) % N : k;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic [AW-1:0] a, input logic wr, input logic [BW-1:0] d);
    r_addr[ch] = a;
    r_wr[ch]   = wr;
    r_data[ch] = d;
    pend[ch]   = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_done"}, BW'(o_done), '0);
    check({tag, "_err"}, BW'(o_err), '0);
    check({tag, "_mreq"}, BW'(o_mreq), '0);
    check({tag, "_maddr"}, BW'(o_maddr), '0);
    check({tag, "_mwr"}, BW'(o_mwr), '0);
    check({tag, "_mdo"}, o_mdo, '0);
    check({tag, "_rdata"}, o_rdata, '0);
  endtask

  // Leaves reset deasserted with nothing pending; caller posts requests before the next edge.
  task automatic do_reset(input bit s);
    reset = 1'b1;
    mem_data_valid = 1'b0;
    pend = '0;
    tick();
    tick();
    sel = s;
    exp_ptr = 0;
    exp_rdata = '0;
    check_zero_outputs("reset");
    reset = 1'b0;
  endtask

  // One transaction as seen by the memory controller; lat = WAIT cycles up to and including valid.
  task automatic serve(input bit rr, input int exp_wait, input int lat, input bit tmo, input bit stray);
    int            w, n;
    logic [AW-1:0] a;
    logic          wr;
    logic [BW-1:0] d, rd;
    w  = model_pick(pend, exp_ptr, rr);
    if (w < 0) w = 0;
    a  = r_addr[w];
    wr = r_wr[w];
    d  = r_data[w];
    n  = 0;
    do begin
      tick();
      n++;
    end while (o_mreq !== 1'b1 && n < 8);
    check("issue_latency", BW'(n), BW'(exp_wait));
    if (o_mreq !== 1'b1) return;
    check("mem_address", BW'(o_maddr), BW'(a));
    check("mem_wr_en", BW'(o_mwr), BW'(wr));
    check("mem_data_out", o_mdo, d);
    check("done_at_issue", BW'(o_done), '0);
    r_addr[w] = ~a;
    r_data[w] = ~d;
    if (stray) begin
      mem_data_valid = 1'b1;
      mem_data_in = rand512();
    end
    tick();
    mem_data_valid = 1'b0;
    check("mem_req_one_cycle", BW'(o_mreq), '0);
    if (tmo) begin
      n = 1;
      while (o_done === '0 && n < 40) begin
        mem_data_in = rand512();
        tick();
        n++;
      end
      check("timeout_cycles", BW'(n), BW'(17));
      check("timeout_err", BW'(o_err), BW'(1));
      check("timeout_rdata", o_rdata, exp_rdata);
    end else begin
      repeat (lat - 1) begin
        mem_data_in = rand512();
        tick();
        check("done_early", BW'(o_done), '0);
      end
      rd = next_rd;
      mem_data_valid = 1'b1;
      mem_data_in = rd;
      tick();
      mem_data_valid = 1'b0;
      mem_data_in = rand512();
      exp_rdata = rd;
      check("resp_err", BW'(o_err), '0);
      check("resp_rdata", o_rdata, exp_rdata);
    end
    check("resp_done", BW'(o_done), BW'(4'b0001 << w));
    check("addr_latched", BW'(o_maddr), BW'(a));
    exp_ptr = (w + 1) % N;
    pend[w] = 1'b0;
    next_rd = rand512();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      r_addr[i] = '0;
      r_wr[i]   = 1'b0;
      r_data[i] = '0;
    end
    next_rd = BW'(64'hDEAD_BEEF);

    do_reset(1'b0);

    // Single read: memory answers three cycles after mem_req.
    set_req(0, 64'h1000, 1'b0, rand512());
    serve(1'b1, 1, 3, 1'b0, 1'b0);
    check("single_read_low_word", BW'(o_rdata[63:0]), BW'(64'hDEAD_BEEF));

    // Write from channel 1.
    set_req(1, 64'h2040, 1'b1, {64{8'hA5}});
    serve(1'b1, 2, 2, 1'b0, 1'b0);

    // Round-robin with all four channels held: order 0,1,2,3,0.
    do_reset(1'b0);
    for (int i = 0; i < N; i++) set_req(i, 64'($urandom), 1'b0, rand512());
    for (int k = 0; k < 5; k++) begin
      check("rr_order", BW'(model_pick(pend, exp_ptr, 1'b1)), BW'(k % N));
      serve(1'b1, (k == 0) ? 1 : 2, 2, 1'b0, 1'b0);
      set_req(k % N, 64'($urandom), 1'b0, rand512());
    end

    // Timeout on channel 2, then a stray valid that must be dropped.
    pend = '0;
    set_req(2, 64'h3000, 1'b0, rand512());
    serve(1'b1, 2, 0, 1'b1, 1'b0);
    mem_data_valid = 1'b1;
    repeat (4) begin
      mem_data_in = rand512();
      tick();
      check("stray_done", BW'(o_done), '0);
      check("stray_mreq", BW'(o_mreq), '0);
      check("stray_rdata", o_rdata, exp_rdata);
    end
    mem_data_valid = 1'b0;
    set_req(0, 64'h4000, 1'b0, rand512());
    serve(1'b1, 1, 1, 1'b0, 1'b0);

    // Reset two cycles after mem_req aborts silently and restarts the pointer.
    set_req(2, 64'h5000, 1'b0, rand512());
    tick();
    tick();
    check("pre_reset_mreq", BW'(o_mreq), BW'(1));
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_zero_outputs("reset_in_wait");
    reset = 1'b0;
    exp_ptr = 0;
    exp_rdata = '0;
    pend = '0;
    set_req(0, 64'h6000, 1'b0, rand512());
    set_req(3, 64'h7000, 1'b1, rand512());
    serve(1'b1, 1, 2, 1'b0, 1'b0);

    // Fixed priority: ch0 re-requests at once and is served twice before ch1.
    do_reset(1'b1);
    set_req(0, 64'h8000, 1'b0, rand512());
    set_req(1, 64'h9000, 1'b0, rand512());
    serve(1'b0, 1, 2, 1'b0, 1'b0);
    set_req(0, 64'h8040, 1'b0, rand512());
    serve(1'b0, 2, 2, 1'b0, 1'b0);
    check("fp_ch1_next", BW'(model_pick(pend, exp_ptr, 1'b0)), BW'(1));
    serve(1'b0, 2, 2, 1'b0, 1'b0);

    // Randomized traffic on both arbitration modes.
    for (int s = 0; s < 2; s++) begin
      do_reset(s[0]);
      set_req($urandom_range(0, N - 1), 64'($urandom), 1'($urandom), rand512());
      for (int t = 0; t < 30; t++) begin
        serve(~s[0], (t == 0) ? 1 : 2, $urandom_range(1, 5),
              ($urandom % 10) == 0, ($urandom % 4) == 0);
        for (int i = 0; i < N; i++)
          if (!pend[i] && ($urandom % 2) == 1)
            set_req(i, {$urandom, $urandom}, 1'($urandom), rand512());
        if (pend == '0) set_req($urandom_range(0, N - 1), 64'($urandom), 1'b0, rand512());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
